// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and message constants (rx FSM states,
//               MARCO pattern, POLO reply).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    // "MARCO\n", first byte in the top octet
    localparam logic [47:0] c_marco_msg   = 48'h4D_41_52_43_4F_0A;
    localparam int          c_marco_len   = 6;
    localparam logic [7:0]  c_marco_first = 8'h4D;
    localparam logic [2:0]  c_marco_last  = 3'd5;

    // "POLO\n" reply sent by the transmitter on a MARCO hit
    localparam logic [39:0] c_polo_msg    = 40'h50_4F_4C_4F_0A;
    localparam int          c_polo_len    = 5;

    function automatic logic [7:0] f_marco_byte(input logic [2:0] idx);
        logic [7:0] v;
        case (idx)
            3'd0:    v = 8'h4D;
            3'd1:    v = 8'h41;
            3'd2:    v = 8'h52;
            3'd3:    v = 8'h43;
            3'd4:    v = 8'h4F;
            3'd5:    v = 8'h0A;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core
// Description : 8N1 UART receiver, oversampled framing with 2-flop input sync.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE   = 16,
    parameter int SAMPLE_POINT = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud16_tick,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [3:0] c_sample = 4'(SAMPLE_POINT);
    localparam logic [3:0] c_last   = 4'(OVERSAMPLE - 1);

    logic       r_sync_1;
    logic       r_rxs;
    logic       r_rxs_d;

    rx_state_t  r_state,  w_state_nxt;
    logic [3:0] r_cnt,    w_cnt_nxt;
    logic [2:0] r_bit,    w_bit_nxt;
    logic [7:0] r_shift,  w_shift_nxt;
    logic [7:0] r_data,   w_data_nxt;
    logic       r_valid,  w_valid_nxt;
    logic       r_ferr,   w_ferr_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_1 <= 1'b1;
            r_rxs    <= 1'b1;
            r_rxs_d  <= 1'b1;
        end else begin
            r_sync_1 <= rx;
            r_rxs    <= r_sync_1;
            r_rxs_d  <= r_rxs;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Edge-triggered start so a line stuck low never re-arms
                if (!r_rxs && r_rxs_d) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = '0;
                end
            end
            ST_START: begin
                if (baud16_tick) begin
                    if (r_cnt == c_sample) begin
                        w_cnt_nxt   = '0;
                        w_bit_nxt   = '0;
                        w_state_nxt = r_rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (baud16_tick) begin
                    if (r_cnt == c_last) begin
                        w_cnt_nxt   = '0;
                        w_shift_nxt = {r_rxs, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            w_state_nxt = ST_STOP;
                        end else begin
                            w_bit_nxt = r_bit + 3'd1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (baud16_tick) begin
                    if (r_cnt == c_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                        if (r_rxs) begin
                            w_data_nxt  = r_shift;
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_ferr_nxt = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_ferr;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_rx_marco.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_marco
// Description : UART receiver that pulses marco_hit on each "MARCO\n".
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_marco
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE   = 16,
    parameter int SAMPLE_POINT = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud16_tick,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       marco_hit,
    output logic       busy
);

    logic [2:0] r_idx;
    logic       r_hit;

    uart_rx_core #(
        .OVERSAMPLE   (OVERSAMPLE),
        .SAMPLE_POINT (SAMPLE_POINT)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .baud16_tick (baud16_tick),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    // A mismatching 'M' restarts the match at index 1 so "MMARCO\n" still hits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
            r_hit <= 1'b0;
        end else begin
            r_hit <= 1'b0;
            if (frame_err) begin
                r_idx <= '0;
            end else if (rx_valid) begin
                if (rx_data == f_marco_byte(r_idx)) begin
                    if (r_idx == c_marco_last) begin
                        r_idx <= '0;
                        r_hit <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end else begin
                    r_idx <= (rx_data == c_marco_first) ? 3'd1 : 3'd0;
                end
            end
        end
    end

    assign marco_hit = r_hit;

endmodule
`default_nettype wire

// File: doc/uart_rx_marco.md
UART_RX_MARCO -- requirements
Module: uart_rx_marco

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, number of baud16_tick pulses per bit.
REQ-002 SHALL have parameter SAMPLE_POINT, default 7, tick count at which a bit is sampled (mid-bit).
REQ-003 clk  input  1  system clock; the only clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 baud16_tick  input  1  one-cycle enable, OVERSAMPLE per bit period.
REQ-006 rx  input  1  asynchronous UART receive line, idle high.
REQ-007 rx_data  output  8  last correctly framed byte, held until the next one.
REQ-008 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-009 frame_err  output  1  one-cycle pulse when the stop bit samples 0.
REQ-010 marco_hit  output  1  one-cycle pulse on completion of "MARCO\n"; drives the uart_tx send input.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rxs; its previous value is rxs_d.
REQ-013 Frame FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE: on rxs==0 && rxs_d==1 (falling edge) -> START, tick counter cleared; a held-low line never starts a frame.
REQ-015 START: on the tick where count==SAMPLE_POINT, rxs==0 -> DATA with counters cleared; rxs==1 -> IDLE (glitch rejected, no output).
REQ-016 DATA: SHALL sample rxs every OVERSAMPLE ticks after the start sample, shift LSB-first into an 8-bit register, and go to STOP after the 8th bit (3-bit bit index, 0..7).
REQ-017 STOP: after OVERSAMPLE further ticks, rxs==1 -> load rx_data, pulse rx_valid, go to IDLE; rxs==0 -> pulse frame_err, leave rx_data unchanged, go to IDLE.
REQ-018 rx_valid and frame_err SHALL assert in the clk cycle after the stop-sample tick, for exactly one cycle.
REQ-019 The tick counter SHALL be 4 bits wide and advance only on baud16_tick; without ticks the FSM holds state.
REQ-020 The matcher SHALL hold a 3-bit index 0..5 against the pattern 4D 41 52 43 4F 0A ("MARCO\n").
REQ-021 On rx_valid: a byte equal to pattern[idx] increments idx; otherwise idx becomes 1 if the byte is 0x4D, else 0.
REQ-022 When the byte matching pattern[5] arrives, marco_hit SHALL pulse in the cycle after rx_valid and idx SHALL return to 0.
REQ-023 frame_err SHALL clear idx to 0.
REQ-024 Overlapping or repeated messages SHALL each produce exactly one marco_hit.

Reset
REQ-025 When rst is high at a clk edge: FSM -> IDLE; counters, idx and shift register -> 0; rx_data -> 0x00; rx_valid, frame_err, marco_hit, busy -> 0; synchronizer flops -> 1.
REQ-026 Reset mid-frame SHALL discard the partial byte, and the next complete frame SHALL be received correctly.

Structure
REQ-027 Package uart_pkg SHALL hold the rx state typedef, the MARCO pattern constants, and the existing POLO message constants.
REQ-028 Framing SHALL sit in one sub-module, uart_rx_core (synchronizer + FSM, outputs rx_data, rx_valid, frame_err); uart_rx_marco instantiates it and adds the matcher.

Verification
REQ-029 Send 0x4D, 16 ticks per bit -> rx_data=0x4D, one rx_valid pulse, frame_err=0, marco_hit=0.
REQ-030 Send "MARCO\n" -> six rx_valid pulses and one marco_hit, one cycle after the 0x0A rx_valid.
REQ-031 Send "MMARCO\n" then "MARCX\nMARCO\n" -> exactly one marco_hit per complete MARCO\n (two total).
REQ-032 Send 0x41 with stop bit 0 -> frame_err pulse, no rx_valid, rx_data unchanged; following "MARCO\n" -> one marco_hit.
REQ-033 rx low for 4 ticks then high -> no rx_valid, no frame_err, busy back to 0 after the start sample.
REQ-034 Assert rst during bit 3 of a byte -> all outputs 0 next cycle; next byte 0xA5 -> rx_data=0xA5.
